swpd_serial_xfer: RTL and testbench

- Parametrised successor to the single-byte SWPD MCU serial engine.
- Integrates bit-clock generation and inter-byte wait timing, so the separate clock and wait helpers are no longer needed.
- Supports multi-byte commands, variable-length replies, poll-timeout and overflow detection, and a coded error result.
- Sits between the SWPD_Control register/command logic and the MCU pins (chip select, clock, data in/out).

---
 rtl/swpd_serial_xfer.sv | 309 ++++++++++++++++++++++++++++++
 tb/tb_swpd_serial_xfer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/swpd_serial_xfer.sv
// swpd_serial_xfer: multi-byte serial transfer engine towards the SWPD MCU.
// Generates chip select, bit clock and inter-byte gap timing internally,
// shifts command bytes out MSB first, then polls with 0x00 bytes and decodes
// the MCU status/data replies into a coded result.
module swpd_serial_xfer #(
  parameter int CLK_DIV    = 4,
  parameter int CS_SETUP   = 8,
  parameter int GAP_CYCLES = 8,
  parameter int MAX_SEND   = 4,
  parameter int MAX_REPLY  = 4,
  parameter int MAX_POLLS  = 255
) (
  input  logic                           clk,
  input  logic                           rst_n,
  output logic                           mcu_clk,
  output logic                           mcu_data_out,
  input  logic                           mcu_data_in,
  output logic                           mcu_chip_select,
  input  logic                           enable,
  input  logic [$clog2(MAX_SEND+1)-1:0]  send_len,
  input  logic [8*MAX_SEND-1:0]          send_data,
  input  logic [$clog2(MAX_REPLY+1)-1:0] reply_len,
  input  logic                           transfer_request,
  output logic                           transfer_running,
  output logic                           transfer_done,
  output logic [7*MAX_REPLY-1:0]         receive_data,
  output logic [$clog2(MAX_REPLY+1)-1:0] receive_count,
  output logic                           transfer_error,
  output logic [2:0]                     error_code
);

  localparam int SLW  = $clog2(MAX_SEND+1);
  localparam int RLW  = $clog2(MAX_REPLY+1);
  localparam int PW   = $clog2(MAX_POLLS+1);
  localparam int RDW  = 7*MAX_REPLY;
  localparam int TM1  = (CS_SETUP > GAP_CYCLES) ? CS_SETUP : GAP_CYCLES;
  localparam int TMAX = (TM1 > 2*CLK_DIV) ? TM1 : 2*CLK_DIV;
  localparam int TW   = $clog2(TMAX+1);

  localparam logic [TW-1:0]  SETUP_LAST = TW'(CS_SETUP-1);
  localparam logic [TW-1:0]  GAP_LAST   = TW'(GAP_CYCLES-1);
  localparam logic [TW-1:0]  CLK_RISE   = TW'(CLK_DIV-1);
  localparam logic [TW-1:0]  BIT_LAST   = TW'(2*CLK_DIV-1);
  localparam logic [PW-1:0]  POLL_MAX   = PW'(MAX_POLLS);
  localparam logic [RLW-1:0] RC_MAX     = RLW'(MAX_REPLY);
  localparam logic [SLW-1:0] SEND_MAX   = SLW'(MAX_SEND);

  localparam logic [2:0] ERR_OK      = 3'd0;
  localparam logic [2:0] ERR_MCU     = 3'd1;
  localparam logic [2:0] ERR_UNKNOWN = 3'd2;
  localparam logic [2:0] ERR_LENGTH  = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT = 3'd4;
  localparam logic [2:0] ERR_OVERFL  = 3'd5;
  localparam logic [2:0] ERR_ABORT   = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t             state_r;
  logic [TW-1:0]      timer_r;
  logic [2:0]         bit_cnt_r;
  logic [7:0]         tx_sh_r;
  logic [7:0]         rx_byte_r;
  logic [SLW-1:0]     send_len_r;
  logic [SLW-1:0]     sent_cnt_r;
  logic [8*MAX_SEND-1:0] send_data_r;
  logic [RLW-1:0]     reply_len_r;
  logic [PW-1:0]      poll_cnt_r;
  logic               mcu_clk_r;
  logic               mcu_data_out_r;
  logic               cs_r;
  logic               running_r;
  logic               done_r;
  logic               error_r;
  logic [2:0]         code_r;
  logic [RDW-1:0]     rdata_r;
  logic [RLW-1:0]     rcount_r;

  logic [7:0]         next_cmd_s;
  logic               cmd_left_s;
  logic [7:0]         tx_byte_s;
  logic [RDW+6:0]     rd_ext_s;
  logic               gap_end_s;
  logic [2:0]         gap_code_s;
  logic               gap_data_s;
  logic               gap_poll_s;

  assign mcu_clk          = mcu_clk_r;
  assign mcu_data_out     = mcu_data_out_r;
  assign mcu_chip_select  = cs_r;
  assign transfer_running = running_r;
  assign transfer_done    = done_r;
  assign transfer_error   = error_r;
  assign error_code       = code_r;
  assign receive_data     = rdata_r;
  assign receive_count    = rcount_r;

  // Select the next latched command byte indexed by the number already sent.
  always_comb begin
    next_cmd_s = 8'h00;
    for (int i = 0; i < MAX_SEND; i++) begin
      if (SLW'(i) == sent_cnt_r) begin
        next_cmd_s = send_data_r[8*i +: 8];
      end else begin
        next_cmd_s = next_cmd_s;
      end
    end
  end

  // Byte to shift next: remaining command bytes first, then 0x00 polls.
  always_comb begin
    cmd_left_s = (sent_cnt_r < send_len_r);
    if (cmd_left_s) begin
      tx_byte_s = next_cmd_s;
    end else begin
      tx_byte_s = 8'h00;
    end
    rd_ext_s = {rdata_r, rx_byte_r[6:0]};
  end

  // Decode the received byte at the end of the gap in priority order.
  always_comb begin
    gap_end_s  = 1'b0;
    gap_code_s = ERR_OK;
    gap_data_s = 1'b0;
    gap_poll_s = 1'b0;
    if (!enable) begin
      gap_end_s  = 1'b1;
      gap_code_s = ERR_ABORT;
    end else if (cmd_left_s) begin
      gap_end_s  = 1'b0;
    end else if (rx_byte_r[7]) begin
      if (rcount_r == RC_MAX) begin
        gap_end_s  = 1'b1;
        gap_code_s = ERR_OVERFL;
      end else begin
        gap_data_s = 1'b1;
      end
    end else if (rx_byte_r == 8'h00) begin
      if (poll_cnt_r == POLL_MAX) begin
        gap_end_s  = 1'b1;
        gap_code_s = ERR_TIMEOUT;
      end else begin
        gap_poll_s = 1'b1;
      end
    end else if (rx_byte_r == 8'h01) begin
      gap_end_s = 1'b1;
      if (rcount_r != reply_len_r) begin
        gap_code_s = ERR_LENGTH;
      end else begin
        gap_code_s = ERR_OK;
      end
    end else if (rx_byte_r == 8'h02) begin
      gap_end_s  = 1'b1;
      gap_code_s = ERR_MCU;
    end else begin
      gap_end_s  = 1'b1;
      gap_code_s = ERR_UNKNOWN;
    end
  end

  // Transfer sequencer: chip select, bit timing, shifting and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      timer_r        <= '0;
      bit_cnt_r      <= 3'd0;
      tx_sh_r        <= 8'h00;
      rx_byte_r      <= 8'h00;
      send_len_r     <= '0;
      sent_cnt_r     <= '0;
      send_data_r    <= '0;
      reply_len_r    <= '0;
      poll_cnt_r     <= '0;
      mcu_clk_r      <= 1'b0;
      mcu_data_out_r <= 1'b0;
      cs_r           <= 1'b0;
      running_r      <= 1'b0;
      done_r         <= 1'b0;
      error_r        <= 1'b0;
      code_r         <= ERR_OK;
      rdata_r        <= '0;
      rcount_r       <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (transfer_request && enable) begin
            state_r     <= ST_SETUP;
            cs_r        <= 1'b1;
            running_r   <= 1'b1;
            timer_r     <= '0;
            sent_cnt_r  <= '0;
            poll_cnt_r  <= '0;
            rdata_r     <= '0;
            rcount_r    <= '0;
            code_r      <= ERR_OK;
            send_data_r <= send_data;
            reply_len_r <= reply_len;
            // A zero length still sends one byte; oversize lengths are clamped.
            if (send_len == '0) begin
              send_len_r <= SLW'(1);
            end else if (send_len > SEND_MAX) begin
              send_len_r <= SEND_MAX;
            end else begin
              send_len_r <= send_len;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_SETUP: begin
          if (timer_r == SETUP_LAST) begin
            state_r        <= ST_SHIFT;
            timer_r        <= '0;
            bit_cnt_r      <= 3'd0;
            mcu_clk_r      <= 1'b0;
            mcu_data_out_r <= tx_byte_s[7];
            tx_sh_r        <= {tx_byte_s[6:0], 1'b0};
            if (cmd_left_s) begin
              sent_cnt_r <= sent_cnt_r + SLW'(1);
            end else begin
              sent_cnt_r <= sent_cnt_r;
            end
          end else begin
            timer_r <= timer_r + TW'(1);
          end
        end
        ST_SHIFT: begin
          if (timer_r == BIT_LAST) begin
            timer_r   <= '0;
            mcu_clk_r <= 1'b0;
            if (bit_cnt_r == 3'd7) begin
              state_r        <= ST_GAP;
              mcu_data_out_r <= 1'b0;
            end else begin
              bit_cnt_r      <= bit_cnt_r + 3'd1;
              mcu_data_out_r <= tx_sh_r[7];
              tx_sh_r        <= {tx_sh_r[6:0], 1'b0};
            end
          end else begin
            timer_r <= timer_r + TW'(1);
            if (timer_r == CLK_RISE) begin
              mcu_clk_r <= 1'b1;
              rx_byte_r <= {rx_byte_r[6:0], mcu_data_in};
            end else begin
              mcu_clk_r <= mcu_clk_r;
            end
          end
        end
        ST_GAP: begin
          if (timer_r == GAP_LAST) begin
            timer_r <= '0;
            if (gap_end_s) begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
              error_r <= (gap_code_s != ERR_OK);
              code_r  <= gap_code_s;
            end else begin
              if (gap_data_s) begin
                rdata_r    <= rd_ext_s[RDW-1:0];
                rcount_r   <= rcount_r + RLW'(1);
                poll_cnt_r <= '0;
              end else if (gap_poll_s) begin
                poll_cnt_r <= poll_cnt_r + PW'(1);
              end else begin
                poll_cnt_r <= poll_cnt_r;
              end
              state_r        <= ST_SHIFT;
              bit_cnt_r      <= 3'd0;
              mcu_clk_r      <= 1'b0;
              mcu_data_out_r <= tx_byte_s[7];
              tx_sh_r        <= {tx_byte_s[6:0], 1'b0};
              if (cmd_left_s) begin
                sent_cnt_r <= sent_cnt_r + SLW'(1);
              end else begin
                sent_cnt_r <= sent_cnt_r;
              end
            end
          end else begin
            timer_r <= timer_r + TW'(1);
          end
        end
        ST_DONE: begin
          state_r   <= ST_IDLE;
          done_r    <= 1'b0;
          error_r   <= 1'b0;
          cs_r      <= 1'b0;
          running_r <= 1'b0;
        end
        default: begin
          state_r        <= ST_IDLE;
          timer_r        <= '0;
          mcu_clk_r      <= 1'b0;
          mcu_data_out_r <= 1'b0;
          cs_r           <= 1'b0;
          running_r      <= 1'b0;
          done_r         <= 1'b0;
          error_r        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_swpd_serial_xfer.sv
// Directed bench for swpd_serial_xfer with a small MCU reply model.
module tb_swpd_serial_xfer;

  logic        clk;
  logic        rst_n;
  logic        mcu_clk;
  logic        mcu_data_out;
  logic        mcu_data_in;
  logic        mcu_chip_select;
  logic        enable;
  logic [2:0]  send_len;
  logic [31:0] send_data;
  logic [2:0]  reply_len;
  logic        transfer_request;
  logic        transfer_running;
  logic        transfer_done;
  logic [27:0] receive_data;
  logic [2:0]  receive_count;
  logic        transfer_error;
  logic [2:0]  error_code;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc;

  swpd_serial_xfer #(
    .CLK_DIV(2), .CS_SETUP(4), .GAP_CYCLES(4),
    .MAX_SEND(4), .MAX_REPLY(4), .MAX_POLLS(3)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .mcu_clk(mcu_clk), .mcu_data_out(mcu_data_out), .mcu_data_in(mcu_data_in),
    .mcu_chip_select(mcu_chip_select), .enable(enable),
    .send_len(send_len), .send_data(send_data), .reply_len(reply_len),
    .transfer_request(transfer_request), .transfer_running(transfer_running),
    .transfer_done(transfer_done), .receive_data(receive_data),
    .receive_count(receive_count), .transfer_error(transfer_error),
    .error_code(error_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // MCU model: one reply byte per shifted byte, advanced on falling bit clock.
  logic [7:0]  reply_mem [0:7];
  logic [3:0]  mcu_byte;
  logic [2:0]  mcu_bit;
  logic        mcu_clk_d;
  logic [63:0] tx_cap;
  logic [7:0]  cur_reply;

  always_comb begin
    if (mcu_byte < 4'd8) cur_reply = reply_mem[mcu_byte[2:0]];
    else                 cur_reply = 8'h00;
  end
  assign mcu_data_in = cur_reply[3'd7 - mcu_bit];

  // Track bit position and capture the transmitted stream on rising bit clock.
  always @(posedge clk) begin
    mcu_clk_d <= mcu_clk;
    if (!mcu_chip_select) begin
      mcu_byte <= 4'd0;
      mcu_bit  <= 3'd0;
    end else if (mcu_clk_d && !mcu_clk) begin
      if (mcu_bit == 3'd7) begin
        mcu_bit  <= 3'd0;
        mcu_byte <= mcu_byte + 4'd1;
      end else begin
        mcu_bit <= mcu_bit + 3'd1;
      end
    end
    if (mcu_clk && !mcu_clk_d) tx_cap <= {tx_cap[62:0], mcu_data_out};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [2:0] len, input logic [31:0] data, input logic [2:0] rlen);
    send_len = len;
    send_data = data;
    reply_len = rlen;
    transfer_request = 1'b1;
    @(negedge clk);
    transfer_request = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int c);
    c = 1;
    while (transfer_done !== 1'b1 && c < budget) begin
      @(negedge clk);
      c++;
    end
    n_assert++;
    assert (transfer_done === 1'b1) else begin
      n_fail++;
      $error("FAIL done_timeout: observed done=%0b expected 1 within %0d cycles", transfer_done, budget);
    end
  endtask

  task automatic set_replies(input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] r2,
                             input logic [7:0] r3, input logic [7:0] r4, input logic [7:0] r5);
    reply_mem[0] = r0; reply_mem[1] = r1; reply_mem[2] = r2;
    reply_mem[3] = r3; reply_mem[4] = r4; reply_mem[5] = r5;
    reply_mem[6] = 8'h03; reply_mem[7] = 8'h03;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; send_len = 3'd0; send_data = 32'h0;
    reply_len = 3'd0; transfer_request = 1'b0;
    set_replies(8'h01, 8'h03, 8'h03, 8'h03, 8'h03, 8'h03);
    repeat (3) @(negedge clk);
    chk("rst_cs", mcu_chip_select, 1'b0);
    chk("rst_clk", mcu_clk, 1'b0);
    chk("rst_dout", mcu_data_out, 1'b0);
    chk("rst_running", transfer_running, 1'b0);
    chk("rst_done", transfer_done, 1'b0);
    chk("rst_err", transfer_error, 1'b0);
    chk("rst_code", error_code, 3'd0);
    chk("rst_rdata", receive_data, 28'h0);
    chk("rst_rcount", receive_count, 3'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single byte 0xA5, MCU answers done.
    start(3'd1, 32'h0000_00A5, 3'd0);
    chk("t1_cs_next", mcu_chip_select, 1'b1);
    chk("t1_running", transfer_running, 1'b1);
    wait_done(400, cyc);
    chk("t1_latency", cyc, 41);
    chk("t1_code", error_code, 3'd0);
    chk("t1_err", transfer_error, 1'b0);
    chk("t1_cs_in_done", mcu_chip_select, 1'b1);
    chk("t1_tx", tx_cap[7:0], 8'hA5);
    @(negedge clk);
    chk("t1_done_pulse", transfer_done, 1'b0);
    chk("t1_cs_idle", mcu_chip_select, 1'b0);
    chk("t1_run_idle", transfer_running, 1'b0);

    // Two command bytes, two data payloads, then done.
    set_replies(8'h55, 8'h81, 8'h85, 8'h01, 8'h03, 8'h03);
    start(3'd2, 32'h0000_3412, 3'd2);
    wait_done(400, cyc);
    chk("t2_latency", cyc, 149);
    chk("t2_code", error_code, 3'd0);
    chk("t2_rdata", receive_data, 28'h0000085);
    chk("t2_rcount", receive_count, 3'd2);
    chk("t2_tx", tx_cap[31:0], 32'h1234_0000);
    @(negedge clk);

    // Wait replies only: timeout on the fourth.
    set_replies(8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03);
    start(3'd2, 32'h0000_3412, 3'd2);
    wait_done(400, cyc);
    chk("t3_latency", cyc, 185);
    chk("t3_code", error_code, 3'd4);
    chk("t3_err", transfer_error, 1'b1);
    chk("t3_rdata_cleared", receive_data, 28'h0);
    chk("t3_rcount", receive_count, 3'd0);
    @(negedge clk);

    // Reply count differs from reply_len.
    set_replies(8'h81, 8'h82, 8'h01, 8'h03, 8'h03, 8'h03);
    start(3'd1, 32'h0000_00C3, 3'd1);
    wait_done(400, cyc);
    chk("t4_code", error_code, 3'd3);
    chk("t4_rdata", receive_data, 28'h0000082);
    chk("t4_rcount", receive_count, 3'd2);
    @(negedge clk);

    // Five data payloads overflow a four-entry buffer.
    set_replies(8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h01);
    start(3'd1, 32'h0000_00C3, 3'd4);
    wait_done(400, cyc);
    chk("t5_code", error_code, 3'd5);
    chk("t5_rcount", receive_count, 3'd4);
    chk("t5_rdata", receive_data, 28'h0208184);
    @(negedge clk);

    // MCU invalid reply.
    set_replies(8'h02, 8'h03, 8'h03, 8'h03, 8'h03, 8'h03);
    start(3'd1, 32'h0000_0011, 3'd0);
    wait_done(400, cyc);
    chk("t6_code", error_code, 3'd1);
    chk("t6_err", transfer_error, 1'b1);
    @(negedge clk);

    // Unknown status reply, then result persists while idle.
    set_replies(8'h05, 8'h03, 8'h03, 8'h03, 8'h03, 8'h03);
    start(3'd0, 32'h0000_0011, 3'd0);
    wait_done(400, cyc);
    chk("t7_latency_len0", cyc, 41);
    chk("t7_code", error_code, 3'd2);
    repeat (20) @(negedge clk);
    chk("t7_code_hold", error_code, 3'd2);
    chk("t7_err_low", transfer_error, 1'b0);

    // Abort: enable low during the first byte.
    set_replies(8'h01, 8'h01, 8'h03, 8'h03, 8'h03, 8'h03);
    start(3'd2, 32'h0000_3412, 3'd0);
    repeat (10) @(negedge clk);
    enable = 1'b0;
    wait_done(400, cyc);
    chk("t8_latency", cyc, 31);
    chk("t8_code", error_code, 3'd7);
    chk("t8_err", transfer_error, 1'b1);
    @(negedge clk);

    // Request with enable low is ignored.
    transfer_request = 1'b1;
    @(negedge clk);
    transfer_request = 1'b0;
    repeat (2) @(negedge clk);
    chk("t9_run_disabled", transfer_running, 1'b0);
    chk("t9_cs_disabled", mcu_chip_select, 1'b0);
    enable = 1'b1;
    @(negedge clk);

    // Request while busy is ignored.
    set_replies(8'h01, 8'h03, 8'h03, 8'h03, 8'h03, 8'h03);
    start(3'd1, 32'h0000_00A5, 3'd0);
    repeat (5) @(negedge clk);
    start(3'd3, 32'h00FF_FFFF, 3'd0);
    wait_done(400, cyc);
    chk("t10_latency", cyc, 35);
    chk("t10_code", error_code, 3'd0);
    chk("t10_tx", tx_cap[7:0], 8'hA5);
    @(negedge clk);
    chk("t10_no_restart", transfer_running, 1'b0);

    // Asynchronous reset while the bit clock is high.
    start(3'd1, 32'h0000_00A5, 3'd0);
    cyc = 0;
    while (mcu_clk !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("t11_clk_high", mcu_clk, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("t11_cs_async", mcu_chip_select, 1'b0);
    chk("t11_clk_async", mcu_clk, 1'b0);
    chk("t11_run_async", transfer_running, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t11_no_done", transfer_done, 1'b0);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t11_idle_after", transfer_running, 1'b0);
    chk("t11_done_after", transfer_done, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
